// File: rtl/addsub8_reg.sv
// Registered 8-bit adder/subtractor: ripple chain of 1-bit add/subtract cells,
// with the result, carry/borrow and signed-overflow flags captured on in_valid.
module addsub8_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   chain;
  logic             ovf_next;

  // chain carries carry in add mode and borrow in subtract mode
  always_comb begin
    sum      = '0;
    chain    = '0;
    chain[0] = cin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ chain[i];
      if (sub)
        chain[i+1] = (~a[i] & b[i]) | (chain[i] & ~(a[i] ^ b[i]));
      else
        chain[i+1] = (a[i] & b[i]) | (chain[i] & (a[i] ^ b[i]));
    end
  end

  always_comb begin
    ovf_next = 1'b0;
    if (sub)
      ovf_next = (a[WIDTH-1] ^ b[WIDTH-1]) & (sum[WIDTH-1] ^ a[WIDTH-1]);
    else
      ovf_next = ~(a[WIDTH-1] ^ b[WIDTH-1]) & (sum[WIDTH-1] ^ a[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s    <= sum;
        cout <= chain[WIDTH];
        ovf  <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_addsub8_reg.sv
// Directed bench for addsub8_reg: reset, add/subtract vectors, overflow,
// hold behaviour and asynchronous mid-cycle reset.
module tb_addsub8_reg;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [7:0] s;
  logic       cout;
  logic       ovf;
  logic       out_valid;

  int compared;
  int mismatched;

  addsub8_reg #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    sub      = 1'b0;
    a        = 8'hFF;
    b        = 8'hFF;
    cin      = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      compared++;
      if ({out_valid, cout, ovf, s} !== 11'h000) begin
        mismatched++;
        $display("FAIL reset[%0d]: got v=%b c=%b o=%b s=%h want v=0 c=0 o=0 s=00",
                 i, out_valid, cout, ovf, s);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Back-to-back vectors, one per cycle; each result checked one edge later.
  task automatic test_add();
    logic [7:0] va [3] = '{8'h1C, 8'h1D, 8'h9C};
    logic [7:0] vb [3] = '{8'hF0, 8'hF2, 8'hFC};
    logic [7:0] es [3] = '{8'h0D, 8'h10, 8'h99};
    @(negedge clk);
    sub = 1'b0;
    cin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a        = va[i];
      b        = vb[i];
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      compared++;
      if ({out_valid, cout, ovf, s} !== {1'b1, 1'b1, 1'b0, es[i]}) begin
        mismatched++;
        $display("FAIL add[%0d]: got v=%b c=%b o=%b s=%h want v=1 c=1 o=0 s=%h",
                 i, out_valid, cout, ovf, s, es[i]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_sub();
    logic [7:0] va [3] = '{8'h1C, 8'h1D, 8'h9C};
    logic [7:0] vb [3] = '{8'hF0, 8'hF2, 8'hFC};
    logic [7:0] es [3] = '{8'h2B, 8'h2A, 8'h9F};
    sub = 1'b1;
    cin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a        = va[i];
      b        = vb[i];
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      compared++;
      if ({out_valid, cout, ovf, s} !== {1'b1, 1'b1, 1'b0, es[i]}) begin
        mismatched++;
        $display("FAIL sub[%0d]: got v=%b c=%b o=%b s=%h want v=1 c=1 o=0 s=%h",
                 i, out_valid, cout, ovf, s, es[i]);
      end
    end
    a   = 8'hF0;
    b   = 8'h1C;
    cin = 1'b0;
    @(posedge clk);
    #1;
    compared++;
    if ({out_valid, cout, ovf, s} !== {1'b1, 1'b0, 1'b0, 8'hD4}) begin
      mismatched++;
      $display("FAIL sub_noborrow: got v=%b c=%b o=%b s=%h want v=1 c=0 o=0 s=d4",
               out_valid, cout, ovf, s);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_overflow();
    sub      = 1'b0;
    a        = 8'h7F;
    b        = 8'h01;
    cin      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    compared++;
    if ({out_valid, cout, ovf, s} !== {1'b1, 1'b0, 1'b1, 8'h80}) begin
      mismatched++;
      $display("FAIL ovf_add: got v=%b c=%b o=%b s=%h want v=1 c=0 o=1 s=80",
               out_valid, cout, ovf, s);
    end
    sub = 1'b1;
    a   = 8'h80;
    b   = 8'h01;
    @(posedge clk);
    #1;
    compared++;
    if ({out_valid, cout, ovf, s} !== {1'b1, 1'b0, 1'b1, 8'h7F}) begin
      mismatched++;
      $display("FAIL ovf_sub: got v=%b c=%b o=%b s=%h want v=1 c=0 o=1 s=7f",
               out_valid, cout, ovf, s);
    end
    in_valid = 1'b0;
  endtask

  // Last captured result is sub 0x80-0x01 (s=7f, ovf=1); inputs churn while idle.
  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      sub = ~sub;
      a   = a + 8'h35;
      b   = b ^ 8'hA5;
      cin = ~cin;
      @(posedge clk);
      #1;
      compared++;
      if ({out_valid, cout, ovf, s} !== {1'b0, 1'b0, 1'b1, 8'h7F}) begin
        mismatched++;
        $display("FAIL hold[%0d]: got v=%b c=%b o=%b s=%h want v=0 c=0 o=1 s=7f",
                 i, out_valid, cout, ovf, s);
      end
    end
  endtask

  task automatic test_async_reset();
    sub      = 1'b0;
    a        = 8'hFF;
    b        = 8'hFF;
    cin      = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    compared++;
    if ({out_valid, cout, ovf, s} !== {1'b1, 1'b1, 1'b0, 8'hFF}) begin
      mismatched++;
      $display("FAIL pre_reset: got v=%b c=%b o=%b s=%h want v=1 c=1 o=0 s=ff",
               out_valid, cout, ovf, s);
    end
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if ({out_valid, cout, ovf, s} !== 11'h000) begin
      mismatched++;
      $display("FAIL async_reset: got v=%b c=%b o=%b s=%h want v=0 c=0 o=0 s=00",
               out_valid, cout, ovf, s);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    compared++;
    if ({out_valid, cout, ovf, s} !== 11'h000) begin
      mismatched++;
      $display("FAIL post_reset_idle: got v=%b c=%b o=%b s=%h want v=0 c=0 o=0 s=00",
               out_valid, cout, ovf, s);
    end
    a        = 8'h12;
    b        = 8'h34;
    cin      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    compared++;
    if ({out_valid, cout, ovf, s} !== {1'b1, 1'b0, 1'b0, 8'h46}) begin
      mismatched++;
      $display("FAIL post_reset_add: got v=%b c=%b o=%b s=%h want v=1 c=0 o=0 s=46",
               out_valid, cout, ovf, s);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    sub        = 1'b0;
    a          = '0;
    b          = '0;
    cin        = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_hold();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
